// File: rtl/ahb_bram_bridge.sv
// AHB-Lite slave bridging a single master onto a dual-port block RAM (write port A, read port B).
// Define BRAM_RAW_FWD_EN to forward write data on read-after-write hazards instead of inserting a wait state.
module ahb_bram_bridge #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [31:0]           dina,
    output logic [3:0]            wea,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [31:0]           doutb
);

    typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [3:0]              mask_reg;
    logic [ADDR_WIDTH-1:0]   haddr_word;
    logic [3:0]              req_mask;
    logic                    accept;
    logic                    hazard;
    logic [3:0]              fwd_lane;
    logic [31:0]             fwd_data;
    logic                    unused_bits;

    assign haddr_word  = HADDR[ADDR_WIDTH+1:2];
    assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    // HSIZE values above halfword all behave as a full word.
    always_comb begin
        req_mask = 4'b1111;
        if (HSIZE == 3'd0) begin
            req_mask = 4'b0001 << HADDR[1:0];
        end else if (HSIZE == 3'd1) begin
            req_mask = HADDR[1] ? 4'b1100 : 4'b0011;
        end
    end

    // Address phases presented while we stall are held by the master and ignored here.
    assign accept = HSEL & HTRANS[1] & HREADY & (state_reg != RD_WAIT);
    assign hazard = accept & ~HWRITE & (state_reg == WR) & (haddr_word == addr_reg);

    always_comb begin
        state_next = state_reg;
        if (state_reg == RD_WAIT) begin
            state_next = RD;
        end else if (accept) begin
            if (HWRITE) begin
                state_next = WR;
            end else if (hazard) begin
`ifdef BRAM_RAW_FWD_EN
                state_next = RD;
`else
                state_next = RD_WAIT;
`endif
            end else begin
                state_next = RD;
            end
        end else begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            mask_reg  <= 4'b0000;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg <= haddr_word;
                mask_reg <= req_mask;
            end
        end
    end

`ifdef BRAM_RAW_FWD_EN
    logic [31:0] fwd_data_reg;
    logic [3:0]  fwd_mask_reg;

    // Capture the in-flight write so the next read cycle can bypass the RAM's stale output.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            fwd_data_reg <= 32'h0;
            fwd_mask_reg <= 4'b0000;
        end else begin
            fwd_mask_reg <= hazard ? mask_reg : 4'b0000;
            if (hazard) begin
                fwd_data_reg <= HWDATA;
            end
        end
    end

    assign fwd_lane = fwd_mask_reg;
    assign fwd_data = fwd_data_reg;
`else
    assign fwd_lane = 4'b0000;
    assign fwd_data = 32'h0;
`endif

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign HRDATA[8*gi +: 8] = (state_reg != RD) ? 8'h00 :
                                       fwd_lane[gi] ? fwd_data[8*gi +: 8] : doutb[8*gi +: 8];
        end
    endgenerate

    assign HREADYOUT = (state_reg != RD_WAIT);
    assign HRESP     = 1'b0;
    assign addra     = addr_reg;
    assign wea       = (state_reg == WR) ? mask_reg : 4'b0000;
    assign dina      = (state_reg == WR) ? HWDATA : 32'h0;
    // During the hazard wait the RAM is re-read after the write has landed.
    assign addrb     = (state_reg == RD_WAIT) ? addr_reg : haddr_word;

endmodule

// File: tb/tb_ahb_bram_bridge.sv
// Bench for ahb_bram_bridge: table-driven AHB transfers with a scoreboard, plus a mid-write reset sequence.
module tb_ahb_bram_bridge;

    localparam int AW = 14;
`ifdef BRAM_RAW_FWD_EN
    localparam int HAZ_WAIT = 0;
`else
    localparam int HAZ_WAIT = 1;
`endif

    logic          clka = 1'b0;
    logic          rst;
    logic          hsel;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic [2:0]    hsize;
    logic          hwrite;
    logic          hready;
    logic [31:0]   hwdata;
    logic          hreadyout;
    logic [31:0]   hrdata;
    logic          hresp;
    logic [AW-1:0] addra;
    logic [31:0]   dina;
    logic [3:0]    wea;
    logic [AW-1:0] addrb;
    logic [31:0]   doutb;

    always #5 clka = ~clka;
    assign hready = hreadyout;

    ahb_bram_bridge #(.ADDR_WIDTH(AW)) dut (
        .clka(clka), .rst(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
        .HWRITE(hwrite), .HREADY(hready), .HWDATA(hwdata), .HREADYOUT(hreadyout), .HRDATA(hrdata),
        .HRESP(hresp), .addra(addra), .dina(dina), .wea(wea), .addrb(addrb), .doutb(doutb)
    );

    // Dual-port RAM with byte enables and a registered (read-first) read port.
    logic [31:0] mem [0:(2**AW)-1];
    always @(posedge clka) begin
        for (int i = 0; i < 4; i++) begin
            if (wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
        end
        doutb <= mem[addrb];
    end

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic [3:0]  exp_mask;
    } vec_t;

    typedef struct {
        int    first;
        int    count;
        int    waits;
        string name;
    } grp_t;

    typedef struct {
        logic          write;
        logic [31:0]   data;
        logic [3:0]    mask;
        logic [AW-1:0] addr;
        int            idx;
    } sb_t;

    vec_t vec [0:63];
    grp_t grp [0:15];
    sb_t  sb [$];
    int   nvec = 0;
    int   ngrp = 0;
    int   grp_start = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic add_v(input logic sel, input logic [1:0] trans, input logic write, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_data,
                         input logic [3:0] exp_mask);
        vec[nvec] = '{sel, trans, write, size, addr, wdata, exp_data, exp_mask};
        nvec++;
    endtask

    task automatic add_w(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata,
                         input logic [3:0] mask);
        add_v(1'b1, 2'b10, 1'b1, size, addr, wdata, 32'h0, mask);
    endtask

    task automatic add_r(input logic [31:0] addr, input logic [31:0] exp);
        add_v(1'b1, 2'b10, 1'b0, 3'd2, addr, 32'h0, exp, 4'b0000);
    endtask

    task automatic add_grp(input string name, input int waits);
        grp[ngrp] = '{grp_start, nvec - grp_start, waits, name};
        ngrp++;
        grp_start = nvec;
    endtask

    task automatic drive_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h0;
    endtask

    // Pipelined AHB master: one address phase overlapping the previous data phase.
    task automatic run_grp(input int g);
        int  ai = grp[g].first;
        int  last = grp[g].first + grp[g].count;
        int  di = 0;
        int  waits = 0;
        int  stall = 0;
        bit  dp_valid = 1'b0;
        bit  done = 1'b0;
        sb_t e;
        while (!done) begin
            @(posedge clka); #1;
            hwdata = (dp_valid && vec[di].write) ? vec[di].wdata : 32'h0;
            if (ai < last) begin
                hsel = vec[ai].sel; htrans = vec[ai].trans; hwrite = vec[ai].write;
                hsize = vec[ai].size; haddr = vec[ai].addr;
            end else begin
                drive_idle();
            end
            @(negedge clka);
            check({grp[g].name, " hresp"}, {31'h0, hresp}, 32'h0);
            if (!(dp_valid && vec[di].write)) check({grp[g].name, " wea idle"}, {28'h0, wea}, 32'h0);
            if (hreadyout) begin
                if (dp_valid) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL %s scoreboard: got empty queue, expected entry", grp[g].name);
                    end else begin
                        e = sb.pop_front();
                        if (e.write) begin
                            check({grp[g].name, " wea"}, {28'h0, wea}, {28'h0, e.mask});
                            check({grp[g].name, " addra"}, {18'h0, addra}, {18'h0, e.addr});
                            check({grp[g].name, " dina"}, dina, e.data);
                            $display("txn %0d write addr=%h wea=%b dina=%h", e.idx, vec[e.idx].addr, wea, dina);
                        end else begin
                            check({grp[g].name, " hrdata"}, hrdata, e.data);
                            $display("txn %0d read  addr=%h hrdata=%h", e.idx, vec[e.idx].addr, hrdata);
                        end
                    end
                end
                dp_valid = 1'b0;
                if (ai < last) begin
                    if (vec[ai].sel && vec[ai].trans[1]) begin
                        sb.push_back('{vec[ai].write, vec[ai].write ? vec[ai].wdata : vec[ai].exp_data,
                                       vec[ai].exp_mask, vec[ai].addr[AW+1:2], ai});
                        dp_valid = 1'b1;
                        di = ai;
                    end else begin
                        $display("txn %0d no-op sel=%b htrans=%b", ai, vec[ai].sel, vec[ai].trans);
                    end
                    ai++;
                end
                stall = 0;
            end else begin
                waits++;
                stall++;
                if (stall > 8) begin
                    n_cmp++; n_bad++;
                    $display("FAIL %s timeout: got %0d stall cycles, expected at most 1", grp[g].name, stall);
                    sb.delete();
                    dp_valid = 1'b0;
                    ai = last;
                end
            end
            if (ai >= last && !dp_valid) done = 1'b1;
        end
        check({grp[g].name, " wait states"}, waits, grp[g].waits);
    endtask

    initial begin
        rst = 1'b1;
        hwdata = 32'h0;
        drive_idle();

        // G0: word write, idle, read back
        add_w(32'h0000_0100, 3'd2, 32'hDEAD_BEEF, 4'b1111);
        add_v(1'b1, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 4'b0000);
        add_r(32'h0000_0100, 32'hDEAD_BEEF);
        add_grp("word_wr_rd", 0);
        // G1: byte lanes over a background word
        add_w(32'h0000_0200, 3'd2, 32'hAAAA_AAAA, 4'b1111);
        add_w(32'h0000_0200, 3'd0, 32'h0000_0011, 4'b0001);
        add_w(32'h0000_0203, 3'd0, 32'h2200_0000, 4'b1000);
        add_v(1'b1, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 4'b0000);
        add_r(32'h0000_0200, 32'h22AA_AA11);
        add_grp("byte_wr", 0);
        // G2: read immediately after a full-word write to the same word
        add_w(32'h0000_0300, 3'd2, 32'h1234_5678, 4'b1111);
        add_r(32'h0000_0300, 32'h1234_5678);
        add_grp("raw_word", HAZ_WAIT);
        // G3: halfword hazard; lower lanes of HWDATA must not leak
        add_w(32'h0000_0300, 3'd2, 32'h0000_0000, 4'b1111);
        add_v(1'b1, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 4'b0000);
        add_w(32'h0000_0302, 3'd1, 32'hBEEF_5555, 4'b1100);
        add_r(32'h0000_0302, 32'hBEEF_0000);
        add_grp("raw_half", HAZ_WAIT);
        // G4: back-to-back writes and reads, different-word read after write, address wrap
        add_w(32'h0000_0010, 3'd2, 32'h0101_0101, 4'b1111);
        add_w(32'h0000_0014, 3'd2, 32'h0202_0202, 4'b1111);
        add_w(32'h0000_0018, 3'd2, 32'h0303_0303, 4'b1111);
        add_w(32'h0000_0020, 3'd7, 32'h0F0F_0F0F, 4'b1111);
        add_r(32'h0000_0010, 32'h0101_0101);
        add_r(32'h0000_0014, 32'h0202_0202);
        add_r(32'h0000_0018, 32'h0303_0303);
        add_r(32'h0001_0100, 32'hDEAD_BEEF);
        add_grp("b2b", 0);
        // G5: IDLE and BUSY while selected, NONSEQ while unselected
        add_v(1'b1, 2'b00, 1'b1, 3'd2, 32'h0000_0100, 32'h0, 32'h0, 4'b0000);
        add_v(1'b0, 2'b10, 1'b1, 3'd2, 32'h0000_0100, 32'h0, 32'h0, 4'b0000);
        add_v(1'b1, 2'b01, 1'b1, 3'd2, 32'h0000_0100, 32'h0, 32'h0, 4'b0000);
        add_r(32'h0000_0100, 32'hDEAD_BEEF);
        add_grp("no_access", 0);
        // G6: background value for the reset test
        add_w(32'h0000_0400, 3'd2, 32'h0BAD_F00D, 4'b1111);
        add_grp("pre_rst", 0);
        // G7: read after the aborted write
        add_r(32'h0000_0400, 32'h0BAD_F00D);
        add_grp("post_rst", 0);

        #3;
        check("reset hreadyout", {31'h0, hreadyout}, 32'h1);
        check("reset hresp", {31'h0, hresp}, 32'h0);
        check("reset wea", {28'h0, wea}, 32'h0);
        check("reset hrdata", hrdata, 32'h0);
        check("reset addra", {18'h0, addra}, 32'h0);
        check("reset dina", dina, 32'h0);
        @(posedge clka);
        @(posedge clka); #1;
        rst = 1'b0;

        for (int g = 0; g < 7; g++) run_grp(g);

        // Reset asserted in the middle of a write data phase
        @(posedge clka); #1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h0000_0400;
        @(posedge clka); #1;
        drive_idle();
        hwdata = 32'hCAFE_F00D;
        #1;
        check("rst_mid wea before", {28'h0, wea}, 32'hF);
        rst = 1'b1;
        #1;
        check("rst_mid wea", {28'h0, wea}, 32'h0);
        check("rst_mid hreadyout", {31'h0, hreadyout}, 32'h1);
        check("rst_mid hrdata", hrdata, 32'h0);
        check("rst_mid addra", {18'h0, addra}, 32'h0);
        $display("txn rst write addr=00000400 aborted wea=%b", wea);
        @(posedge clka); #1;
        rst = 1'b0;
        hwdata = 32'h0;

        run_grp(7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
